// File: rtl/hsv_zone_trigger_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hsv_zone_trigger_if                                             |
// | Brief    : Pixel/HSV/config inputs and detection outputs of the zone trigger|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface hsv_zone_trigger_if #(
  parameter int H_MAX   = 800,
  parameter int V_MAX   = 525,
  parameter int N_ZONES = 2,
  parameter int EVT_W   = 15
);
  localparam int c_XW = $clog2(H_MAX);
  localparam int c_YW = $clog2(V_MAX);

  logic                     den;
  logic [c_XW-1:0]          x_pixel;
  logic [c_YW-1:0]          y_pixel;
  logic [9:0]               h_in;
  logic [6:0]               s_in;
  logic [6:0]               v_in;
  logic [9:0]               cfg_h_min;
  logic [9:0]               cfg_h_max;
  logic [6:0]               cfg_s_min;
  logic [6:0]               cfg_s_max;
  logic [6:0]               cfg_v_min;
  logic [6:0]               cfg_v_max;
  logic                     pix_hit;
  logic [N_ZONES-1:0]       zone_det;
  logic [N_ZONES-1:0]       trig_pulse;
  logic [N_ZONES*EVT_W-1:0] evt_cnt;
  logic                     sys_ready;

  modport master (
    output den, x_pixel, y_pixel, h_in, s_in, v_in,
    output cfg_h_min, cfg_h_max, cfg_s_min, cfg_s_max, cfg_v_min, cfg_v_max,
    input  pix_hit, zone_det, trig_pulse, evt_cnt, sys_ready
  );

  modport slave (
    input  den, x_pixel, y_pixel, h_in, s_in, v_in,
    input  cfg_h_min, cfg_h_max, cfg_s_min, cfg_s_max, cfg_v_min, cfg_v_max,
    output pix_hit, zone_det, trig_pulse, evt_cnt, sys_ready
  );
endinterface
`default_nettype wire

// File: rtl/hsv_zone_trigger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hsv_zone_trigger                                                |
// | Brief    : HSV window classifier with per-zone hit counting and triggers   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module hsv_zone_trigger #(
  parameter int H_MAX          = 800,
  parameter int V_MAX          = 525,
  parameter int ACT_W          = 640,
  parameter int N_ZONES        = 2,
  parameter int CNT_W          = 12,
  parameter int HIT_THR        = 6,
  parameter int STARTUP_FRAMES = 10,
  parameter int RELEASE_FRAMES = 1,
  parameter int EVT_W          = 15
) (
  input  logic                 pclk,
  input  logic                 rstn,
  hsv_zone_trigger_if.slave    bus
);
  localparam int c_XW  = $clog2(H_MAX);
  localparam int c_YW  = $clog2(V_MAX);
  localparam int c_ZW  = ACT_W / N_ZONES;
  localparam int c_FW  = $clog2(STARTUP_FRAMES + 1);
  localparam int c_RW  = $clog2(RELEASE_FRAMES + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  logic                     w_match;
  logic                     w_frame_end;
  logic                     r_pix_hit;
  logic [c_FW-1:0]          r_frame_cnt;
  logic                     r_sys_ready;
  logic [N_ZONES-1:0]       w_zone_det;
  logic [N_ZONES-1:0]       w_trig;
  logic [N_ZONES*EVT_W-1:0] w_evt;

  // An inverted window (min > max) can never satisfy both bounds, so it never matches.
  assign w_match = bus.den
                 && (bus.h_in >= bus.cfg_h_min) && (bus.h_in <= bus.cfg_h_max)
                 && (bus.s_in >= bus.cfg_s_min) && (bus.s_in <= bus.cfg_s_max)
                 && (bus.v_in >= bus.cfg_v_min) && (bus.v_in <= bus.cfg_v_max);

  assign w_frame_end = (bus.x_pixel == c_XW'(H_MAX - 1))
                    && (bus.y_pixel == c_YW'(V_MAX - 1));

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      r_pix_hit   <= 1'b0;
      r_frame_cnt <= '0;
      r_sys_ready <= 1'b0;
    end else begin
      r_pix_hit <= w_match;
      if (w_frame_end && !r_sys_ready) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        if (r_frame_cnt == c_FW'(STARTUP_FRAMES - 1)) begin
          r_sys_ready <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_ZONES; k++) begin : g_zone
    localparam int c_LO = k * c_ZW;
    localparam int c_HI = (k + 1) * c_ZW;

    logic             w_hit;
    logic [CNT_W-1:0] r_hit_cnt;
    logic             r_det;
    logic             r_trig;
    logic [EVT_W-1:0] r_evt;
    logic [c_RW-1:0]  r_rel_cnt;
    state_t           r_state;

    assign w_hit = w_match
                && (int'(bus.x_pixel) >= c_LO)
                && (int'(bus.x_pixel) <  c_HI);

    always_ff @(posedge pclk) begin
      if (!rstn) begin
        r_hit_cnt <= '0;
        r_det     <= 1'b0;
      end else if (w_frame_end) begin
        r_hit_cnt <= '0;
        r_det     <= 1'b0;
      end else if (w_hit) begin
        if (r_hit_cnt != c_CNT_MAX) begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
        end
        if (({1'b0, r_hit_cnt} + (CNT_W+1)'(1)) >= (CNT_W+1)'(HIT_THR)) begin
          r_det <= 1'b1;
        end
      end
    end

    // r_det here is the pre-clear value on the frame_end edge.
    always_ff @(posedge pclk) begin
      if (!rstn) begin
        r_state   <= S_IDLE;
        r_rel_cnt <= '0;
        r_trig    <= 1'b0;
        r_evt     <= '0;
      end else begin
        r_trig <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (r_sys_ready && r_det) begin
              r_trig    <= 1'b1;
              r_evt     <= r_evt + 1'b1;
              r_rel_cnt <= '0;
              r_state   <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (w_frame_end) begin
              if (r_det) begin
                r_rel_cnt <= '0;
              end else if (({1'b0, r_rel_cnt} + (c_RW+1)'(1)) == (c_RW+1)'(RELEASE_FRAMES)) begin
                r_rel_cnt <= '0;
                r_state   <= S_IDLE;
              end else begin
                r_rel_cnt <= r_rel_cnt + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign w_zone_det[k]              = r_det;
    assign w_trig[k]                  = r_trig;
    assign w_evt[k*EVT_W +: EVT_W]    = r_evt;
  end

  assign bus.pix_hit    = r_pix_hit;
  assign bus.zone_det   = w_zone_det;
  assign bus.trig_pulse = w_trig;
  assign bus.evt_cnt    = w_evt;
  assign bus.sys_ready  = r_sys_ready;
endmodule
`default_nettype wire

// File: tb/tb_hsv_zone_trigger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hsv_zone_trigger                                             |
// | Brief    : Bench for hsv_zone_trigger (2-zone/REL=1 and 4-zone/REL=2 DUTs) |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hsv_zone_trigger;
  localparam int H_MAX = 800;
  localparam int V_MAX = 525;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  hsv_zone_trigger_if #(.N_ZONES(2)) ifA ();
  hsv_zone_trigger_if #(.N_ZONES(4)) ifB ();

  hsv_zone_trigger #(.N_ZONES(2), .RELEASE_FRAMES(1)) dutA (.pclk(clk), .rstn(rstn), .bus(ifA));
  hsv_zone_trigger #(.N_ZONES(4), .RELEASE_FRAMES(2)) dutB (.pclk(clk), .rstn(rstn), .bus(ifB));

  typedef struct {
    logic [69:0] v;
    string       nm;
  } exp_t;

  typedef struct {
    logic       den;
    int         x;
    logic       col;
    logic       e_pix;
    logic [3:0] e_det;
    logic [3:0] e_trig;
    int         e_ev0;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[$];
  int         checks   = 0;
  int         failures = 0;
  logic       chkB     = 1'b0;
  logic       erdy     = 1'b0;
  int         eev[4]   = '{0, 0, 0, 0};
  logic [9:0] hue_match = 10'd120;

  task automatic set_cfg(input logic [9:0] hmin, input logic [9:0] hmax);
    ifA.cfg_h_min = hmin; ifA.cfg_h_max = hmax;
    ifA.cfg_s_min = 7'd20; ifA.cfg_s_max = 7'd100;
    ifA.cfg_v_min = 7'd20; ifA.cfg_v_max = 7'd100;
    ifB.cfg_h_min = hmin; ifB.cfg_h_max = hmax;
    ifB.cfg_s_min = 7'd20; ifB.cfg_s_max = 7'd100;
    ifB.cfg_v_min = 7'd20; ifB.cfg_v_max = 7'd100;
  endtask

  task automatic drive(input logic den, input int x, input logic col);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = 10'(x);
    yv = (x == H_MAX - 1) ? 10'(V_MAX - 1) : 10'd10;
    ifA.den = den; ifA.x_pixel = xv; ifA.y_pixel = yv;
    ifA.h_in = col ? hue_match : 10'd0;
    ifA.s_in = col ? 7'd50 : 7'd0;
    ifA.v_in = col ? 7'd50 : 7'd0;
    ifB.den = den; ifB.x_pixel = xv; ifB.y_pixel = yv;
    ifB.h_in = ifA.h_in; ifB.s_in = ifA.s_in; ifB.v_in = ifA.v_in;
  endtask

  // One clock: drive, queue the expected outputs, then compare after the edge.
  task automatic step(input logic den, input int x, input logic col, input logic e_pix,
                      input logic [3:0] e_det, input logic [3:0] e_trig, input string nm);
    exp_t        e;
    logic [59:0] ev;
    logic [69:0] act;
    drive(den, x, col);
    if (chkB) ev = {eev[3][14:0], eev[2][14:0], eev[1][14:0], eev[0][14:0]};
    else      ev = {30'd0, eev[1][14:0], eev[0][14:0]};
    e.v  = {e_pix, e_det, e_trig, ev, erdy};
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (chkB) act = {ifB.pix_hit, ifB.zone_det, ifB.trig_pulse, ifB.evt_cnt, ifB.sys_ready};
    else      act = {ifA.pix_hit, 2'b00, ifA.zone_det, 2'b00, ifA.trig_pulse,
                     30'd0, ifA.evt_cnt, ifA.sys_ready};
    e = sb.pop_front();
    checks++;
    if (act !== e.v) begin
      failures++;
      $display("FAIL %s: got pix/det/trig/evt/rdy=%0b/%b/%b/%h/%0b want %0b/%b/%b/%h/%0b",
               e.nm, act[69], act[68:65], act[64:61], act[60:1], act[0],
               e.v[69], e.v[68:65], e.v[64:61], e.v[60:1], e.v[0]);
    end
  endtask

  task automatic fe(input string nm);
    step(1'b0, H_MAX - 1, 1'b0, 1'b0, 4'b0000, 4'b0000, nm);
  endtask

  // n matching pixels at column x; zone bit zb is expected to rise on the 6th.
  task automatic hits(input int n, input int x, input int zb, input logic [3:0] base,
                      input string nm);
    for (int i = 1; i <= n; i++) begin
      step(1'b1, x, 1'b1, 1'b1, base | ((i >= 6) ? 4'(1 << zb) : 4'b0000), 4'b0000, nm);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 100, 1'b1, 1'b1, 4'b0000, 4'b0000, 0});
    tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 4'b0000, 4'b0000, 0});
    tbl.push_back('{1'b0, 799, 1'b0, 1'b0, 4'b0000, 4'b0000, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 100, 1'b1, 1'b1, 4'b0000, 4'b0000, 0});
    tbl.push_back('{1'b1, 100, 1'b1, 1'b1, 4'b0001, 4'b0000, 0});
    tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 4'b0001, 4'b0001, 1});
    tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 4'b0001, 4'b0000, 1});
    tbl.push_back('{1'b0, 799, 1'b0, 1'b0, 4'b0000, 4'b0000, 1});

    set_cfg(10'd90, 10'd150);
    rstn = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0, 4'b0000, 4'b0000, "reset0");
    step(1'b0, 0, 1'b0, 1'b0, 4'b0000, 4'b0000, "reset1");
    rstn = 1'b1;

    // Startup: ready exactly on the 10th frame end, no triggers.
    for (int f = 1; f <= 11; f++) begin
      step(1'b1, 10, 1'b0, 1'b0, 4'b0000, 4'b0000, "t1_pix");
      erdy = (f >= 10);
      fe("t1_fe");
    end

    // Threshold: 5 hits no detect, 6 hits detect and pulse.
    foreach (tbl[i]) begin
      eev[0] = tbl[i].e_ev0;
      step(tbl[i].den, tbl[i].x, tbl[i].col, tbl[i].e_pix, tbl[i].e_det, tbl[i].e_trig, "t2_tbl");
    end

    // Hold across detecting frames, release after one empty frame.
    hits(6, 100, 0, 4'b0000, "t3_f2"); fe("t3_f2_fe");
    hits(6, 100, 0, 4'b0000, "t3_f3"); fe("t3_f3_fe");
    step(1'b1, 100, 1'b0, 1'b0, 4'b0000, 4'b0000, "t3_empty"); fe("t3_empty_fe");
    hits(6, 100, 0, 4'b0000, "t3_rearm");
    eev[0] = 2;
    step(1'b1, 100, 1'b0, 1'b0, 4'b0001, 4'b0001, "t3_pulse2");
    step(1'b1, 100, 1'b0, 1'b0, 4'b0001, 4'b0000, "t3_after");
    fe("t3_fe"); fe("t3_release");

    // Inverted and degenerate windows, out-of-zone columns, zone boundary.
    set_cfg(10'd40, 10'd30); hue_match = 10'd35;
    for (int i = 0; i < 6; i++) step(1'b1, 100, 1'b1, 1'b0, 4'b0000, 4'b0000, "t5_inverted");
    set_cfg(10'd35, 10'd35);
    step(1'b1, 700, 1'b1, 1'b1, 4'b0000, 4'b0000, "t5_equal_bounds");
    set_cfg(10'd90, 10'd150); hue_match = 10'd120;
    for (int i = 0; i < 6; i++) step(1'b1, 640, 1'b1, 1'b1, 4'b0000, 4'b0000, "t5_x640");
    step(1'b1, 640, 1'b0, 1'b0, 4'b0000, 4'b0000, "t5_x640_quiet");
    hits(5, 319, 0, 4'b0000, "t5_x319");
    step(1'b1, 320, 1'b1, 1'b1, 4'b0000, 4'b0000, "t5_x320");
    fe("t5_fe");
    hits(6, 639, 1, 4'b0000, "t5_x639");
    eev[1] = 1;
    step(1'b1, 639, 1'b0, 1'b0, 4'b0010, 4'b0010, "t5_z1_pulse");
    step(1'b1, 639, 1'b0, 1'b0, 4'b0010, 4'b0000, "t5_z1_hold");

    // Mid-frame reset while zone 1 holds: everything clears, startup restarts.
    hits(4, 0, 0, 4'b0010, "t6_pre");
    rstn = 1'b0;
    eev = '{0, 0, 0, 0};
    erdy = 1'b0;
    step(1'b1, 0, 1'b1, 1'b0, 4'b0000, 4'b0000, "t6_reset");
    rstn = 1'b1;
    hits(6, 0, 0, 4'b0000, "t6_fresh");
    step(1'b1, 0, 1'b0, 1'b0, 4'b0001, 4'b0000, "t6_no_trig_startup");
    for (int f = 1; f <= 10; f++) begin
      erdy = (f == 10);
      fe("t6_startup_fe");
    end
    step(1'b1, 10, 1'b0, 1'b0, 4'b0000, 4'b0000, "t6_ready_quiet");

    // Four zones, two-frame release.
    chkB = 1'b1;
    hits(6, 170, 1, 4'b0000, "t4_z1");
    eev[1] = 1;
    step(1'b1, 170, 1'b0, 1'b0, 4'b0010, 4'b0010, "t4_pulse");
    fe("t4_fe"); fe("t4_empty1");
    hits(6, 170, 1, 4'b0000, "t4_rehit");
    step(1'b1, 170, 1'b0, 1'b0, 4'b0010, 4'b0000, "t4_no_retrig");
    fe("t4_rehit_fe"); fe("t4_empty_a"); fe("t4_empty_b");
    hits(6, 170, 1, 4'b0000, "t4_rearm");
    eev[1] = 2;
    step(1'b1, 170, 1'b0, 1'b0, 4'b0010, 4'b0010, "t4_pulse2");
    step(1'b1, 170, 1'b0, 1'b0, 4'b0010, 4'b0000, "t4_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
